// File: rtl/ascii_time_encoder.sv
// ascii_time_encoder: sends a "HH:MM:SS.CC[CR LF]" time report to a UART one byte at a time; optional AUTO_REPORT_EN adds a report on every seconds change
module ascii_time_encoder #(
  parameter int SEND_CRLF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_send,
  input  logic [23:0] time_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
  localparam logic [3:0] LAST = (SEND_CRLF != 0) ? 4'd12 : 4'd10;
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [23:0] snap_q, snap_d;
  logic [7:0]  tx_data_q, tx_data_d, cur_byte;
  logic        req;
  function automatic logic [7:0] dig(input logic [6:0] v, input logic ones);
    logic [6:0] s;
    s = (v > 7'd99) ? 7'd99 : v;
    return ones ? 8'h30 + 8'(s % 7'd10) : 8'h30 + 8'(s / 7'd10);
  endfunction
`ifdef AUTO_REPORT_EN
  logic [5:0] sec_q, sec_d;
  logic       armed_q, armed_d;
  // armed_q masks the first cycle after reset, when sec_q still holds its reset value
  always_comb begin
    sec_d   = time_data[12:7];
    armed_d = 1'b1;
    req     = i_send | (armed_q && (time_data[12:7] != sec_q));
  end
  // previous-cycle seconds field for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      armed_q <= armed_d;
    end
  end
`else
  assign req = i_send;
`endif
  // byte selected by the frame index from the snapshot
  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      4'd0:  cur_byte = dig({2'b0, snap_q[23:19]}, 1'b0);
      4'd1:  cur_byte = dig({2'b0, snap_q[23:19]}, 1'b1);
      4'd3:  cur_byte = dig({1'b0, snap_q[18:13]}, 1'b0);
      4'd4:  cur_byte = dig({1'b0, snap_q[18:13]}, 1'b1);
      4'd6:  cur_byte = dig({1'b0, snap_q[12:7]}, 1'b0);
      4'd7:  cur_byte = dig({1'b0, snap_q[12:7]}, 1'b1);
      4'd2, 4'd5: cur_byte = 8'h3A;
      4'd8:  cur_byte = 8'h2E;
      4'd9:  cur_byte = dig(snap_q[6:0], 1'b0);
      4'd10: cur_byte = dig(snap_q[6:0], 1'b1);
      4'd11: cur_byte = 8'h0D;
      4'd12: cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end
  // handshake FSM: one strobe per byte, then wait for the transmitter's busy pulse to finish
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    case (state_q)
      IDLE: if (req) begin
        snap_d  = time_data;
        idx_d   = 4'd0;
        state_d = SEND;
      end
      SEND:    state_d = WAIT_HI;
      WAIT_HI: state_d = tx_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: if (!tx_busy) begin
        state_d = (idx_q == LAST) ? IDLE : SEND;
        idx_d   = (idx_q == LAST) ? idx_q : idx_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    tx_start  = (state_q == SEND);
    tx_data   = tx_start ? cur_byte : tx_data_q;
    tx_data_d = tx_data;
    o_busy    = (state_q != IDLE);
  end
  // state, index, snapshot and last-sent byte registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      tx_data_q <= tx_data_d;
    end
  end
endmodule

// File: tb/tb_ascii_time_encoder.sv
// tb_ascii_time_encoder: randomized and directed checks of ascii_time_encoder against a frame-level reference model
module tb_ascii_time_encoder;
  logic        clk, rst, i_send, tx_busy, tx_busy0;
  logic [23:0] time_data;
  logic        tx_start, o_busy, tx_start0, o_busy0;
  logic [7:0]  tx_data, tx_data0;
  int          n_cmp = 0, n_bad = 0, ns = 0, ns0 = 0;
  string       got = "", got0 = "", crlf;
  bit          fixed10 = 0;

  ascii_time_encoder #(.SEND_CRLF(1)) dut (
    .clk(clk), .rst(rst), .i_send(i_send), .time_data(time_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .o_busy(o_busy));
  ascii_time_encoder #(.SEND_CRLF(0)) dut0 (
    .clk(clk), .rst(rst), .i_send(i_send), .time_data(time_data), .tx_busy(tx_busy0),
    .tx_start(tx_start0), .tx_data(tx_data0), .o_busy(o_busy0));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int sat(int v);
    return v > 99 ? 99 : v;
  endfunction

  function automatic string fmt(logic [23:0] t, bit cr);
    string s;
    s = $sformatf("%02d:%02d:%02d.%02d", sat(int'(t[23:19])), sat(int'(t[18:13])),
                  sat(int'(t[12:7])), sat(int'(t[6:0])));
    if (cr) s = {s, $sformatf("%c%c", 8'h0d, 8'h0a)};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse;
    cyc;
    i_send = 1;
    cyc;
    i_send = 0;
  endtask

  task automatic wait_frame(input bit which0);
    int n = 0;
    bit seen = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (which0 ? o_busy0 : o_busy) seen = 1;
      else if (seen) break;
      n++;
    end
    chk("frame_done", n < 3000, 1);
  endtask

  task automatic set_time(input logic [23:0] v);
    int n = 0;
    cyc;
    time_data = v;
    repeat (3) cyc;
    while ((o_busy || o_busy0) && n < 3000) begin
      cyc;
      n++;
    end
    got = ""; ns = 0; got0 = ""; ns0 = 0;
  endtask

  // transmitter for the CRLF instance: busy rises after 0-2 cycles and lasts 1-6 cycles (or exactly 10)
  initial begin
    int d, l;
    tx_busy = 0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        d = fixed10 ? 0 : $urandom_range(0, 2);
        l = fixed10 ? 10 : $urandom_range(1, 6);
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 tx_busy = 1;
        repeat (l) @(posedge clk);
        #1 tx_busy = 0;
      end
    end
  end

  // transmitter for the no-CRLF instance: fixed 3-cycle busy
  initial begin
    tx_busy0 = 0;
    forever begin
      @(negedge clk);
      if (tx_start0) begin
        @(posedge clk);
        #1 tx_busy0 = 1;
        repeat (3) @(posedge clk);
        #1 tx_busy0 = 0;
      end
    end
  end

  // reference model and per-cycle compare: a frame is a string; each byte goes out one cycle after acceptance
  // or after the transmitter has raised and then dropped busy for the previous byte
  initial begin : cmp
    string      m_frame = "";
    int         m_pos = 0;
    bit         m_active = 0, m_start = 0, m_seen_hi = 0, m_armed = 0, req;
    logic [7:0] m_last = 0, exp_d;
    logic [5:0] m_sec = 0;
    forever begin
      @(negedge clk);
      exp_d = m_start ? m_frame[m_pos] : m_last;
      chk("tx_start", tx_start, m_start);
      chk("o_busy", o_busy, m_active);
      chk("tx_data", tx_data, exp_d);
      if (tx_start) begin got = {got, $sformatf("%c", tx_data)}; ns++; end
      if (tx_start0) begin got0 = {got0, $sformatf("%c", tx_data0)}; ns0++; end
      m_last = exp_d;
      if (rst) begin
        m_active = 0; m_start = 0; m_seen_hi = 0; m_last = 0; m_pos = 0; m_sec = 0; m_armed = 0;
      end else begin
        req = i_send;
`ifdef AUTO_REPORT_EN
        req = req | (m_armed && time_data[12:7] != m_sec);
`endif
        m_sec = time_data[12:7];
        m_armed = 1;
        if (!m_active) begin
          if (req) begin
            m_frame = fmt(time_data, 1); m_pos = 0; m_active = 1; m_start = 1;
          end
        end else if (m_start) begin
          m_start = 0; m_seen_hi = 0;
        end else if (!m_seen_hi) m_seen_hi = tx_busy;
        else if (!tx_busy) begin
          if (m_pos == m_frame.len() - 1) m_active = 0;
          else begin m_pos++; m_start = 1; end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] t1;
    int n;
    crlf = $sformatf("%c%c", 8'h0d, 8'h0a);
    rst = 1; i_send = 0; time_data = 0;
    repeat (2) cyc;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_o_busy", o_busy, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    cyc;
    rst = 0;
    chk_s("pin_fmt_basic", fmt({5'd12, 6'd34, 6'd56, 7'd78}, 1), {"12:34:56.78", crlf});
    chk_s("pin_fmt_sat", fmt({5'd31, 6'd0, 6'd0, 7'd127}, 0), "31:00:00.99");

    fixed10 = 1;
    t1 = {5'd12, 6'd34, 6'd56, 7'd78};
    set_time(t1);
    pulse;
    wait_frame(0);
    chk("busy_low_at_end", tx_busy, 0);
    chk_s("frame_12_34", got, {"12:34:56.78", crlf});
    chk("starts_13", ns, 13);
    fixed10 = 0;

    set_time(24'd0);
    pulse;
    wait_frame(1);
    chk_s("frame_nocrlf", got0, "00:00:00.00");
    chk("starts_11", ns0, 11);

    set_time({5'd31, 6'd0, 6'd0, 7'd127});
    pulse;
    wait_frame(0);
    chk_s("frame_sat", got, {"31:00:00.99", crlf});

    set_time(t1);
    pulse;
    repeat (15) cyc;
    time_data = {5'd3, 6'd4, 6'd56, 7'd9};
    pulse;
    wait_frame(0);
    chk_s("frame_snapshot", got, {"12:34:56.78", crlf});
    repeat (40) cyc;
    chk("no_queued_frame", ns, 13);

    set_time(t1);
    pulse;
    n = 0;
    while (ns < 5 && n < 3000) begin cyc; n++; end
    chk("reached_byte5", ns, 5);
    rst = 1;
    cyc;
    rst = 0;
    chk("abort_tx_start", tx_start, 0);
    chk("abort_o_busy", o_busy, 0);
    repeat (20) cyc;
    chk_s("aborted_prefix", got, "12:34");
    got = ""; ns = 0;
    pulse;
    wait_frame(0);
    chk_s("frame_after_abort", got, {"12:34:56.78", crlf});

    set_time({5'd1, 6'd2, 6'd9, 7'd3});
    repeat (20) cyc;
    chk("no_frame_const_sec", ns, 0);
    time_data = {5'd1, 6'd2, 6'd10, 7'd3};
`ifdef AUTO_REPORT_EN
    wait_frame(0);
    chk_s("auto_frame", got, {"01:02:10.03", crlf});
    repeat (20) cyc;
    chk("auto_one_frame", ns, 13);
`else
    repeat (20) cyc;
    chk("no_auto_frame", ns, 0);
`endif

    for (int i = 0; i < 1500; i++) begin
      cyc;
      i_send = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) time_data = $urandom;
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 0; i_send = 0;
    repeat (300) cyc;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ascii_time_encoder.md
ASCII_TIME_ENCODER -- requirements
Module: ascii_time_encoder

Interface
REQ-001 SHALL have parameter: SEND_CRLF, 1, nonzero appends CR (8'h0D) and LF (8'h0A) after the time string.
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_send  input  1  report request, sampled every cycle.
REQ-005 SHALL have port: time_data  input  24  packed time; [23:19] hour, [18:13] min, [12:7] sec, [6:0] centisec.
REQ-006 SHALL have port: tx_busy  input  1  UART transmitter busy flag.
REQ-007 SHALL have port: tx_start  output  1  one-cycle byte-send strobe to the UART transmitter.
REQ-008 SHALL have port: tx_data  output  8  ASCII byte, valid while tx_start is high.
REQ-009 SHALL have port: o_busy  output  1  high while a report is in progress.

Function
REQ-010 SHALL transmit the frame "HH:MM:SS.CC", followed by CR LF when SEND_CRLF is nonzero: 13 bytes with CRLF, 11 bytes without.
REQ-011 SHALL capture time_data into a snapshot register on the cycle a request is accepted, so the whole frame reflects one instant.
REQ-012 SHALL format each field as two ASCII decimal digits, tens first (8'h30 + digit).
REQ-013 SHALL saturate any field value above 99 to "99" (example: centisec 7'd120 -> "99"); values 0-99 SHALL print unmodified, with no range check against 23 or 59.
REQ-014 SHALL implement FSM states IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE: on i_send=1 -> snapshot, byte index=0, go to SEND.
- SEND: assert tx_start for exactly one cycle with tx_data=byte[index], go to WAIT_HI.
- WAIT_HI: stay until tx_busy=1, then go to WAIT_LO.
- WAIT_LO: stay until tx_busy=0; if index is the last byte go to IDLE, else index+1 and go to SEND.
REQ-015 SHALL hold tx_data at the last sent byte whenever tx_start is low.
REQ-016 SHALL drive o_busy=1 in every state except IDLE.
REQ-017 SHALL ignore i_send while o_busy=1, with no queuing; a request arriving on the same cycle the FSM returns to IDLE SHALL also be ignored.
REQ-018 SHALL accept a request held high continuously as back-to-back frames, each new frame starting on the cycle after return to IDLE, when i_send is still sampled high.
REQ-019 SHALL need no more than 2 cycles from the tx_busy falling edge to the next tx_start.
REQ-020 SHALL latch byte index and snapshot only in IDLE (on accept) and WAIT_LO (increment), holding them otherwise.

Reset
REQ-021 SHALL, while rst=1, force state=IDLE, index=0, snapshot=0, tx_start=0, tx_data=8'h00 and o_busy=0 on the next rising edge.
REQ-022 SHALL abort a frame on mid-frame reset with no further tx_start; a new request after reset release SHALL start from byte 0.

Configuration
REQ-023 SHALL, when macro AUTO_REPORT_EN is defined, register the time_data sec field each cycle and raise an internal request when it differs from the previous cycle's value, ORed with i_send under the same REQ-017 rules.
REQ-024 SHALL, when AUTO_REPORT_EN is undefined, omit the sec-change detector entirely, so reports start only from i_send.
REQ-025 SHALL suppress the auto request on the first cycle after reset, with the sec register reset to 0.

Verification
REQ-026 SHALL cover: time_data={5'd12,6'd34,6'd56,7'd78}, i_send pulse, transmitter model with busy of 10 cycles -> bytes "12:34:56.78\r\n", 13 tx_start pulses, o_busy falls after the last busy drop.
REQ-027 SHALL cover: SEND_CRLF=0, time_data=0 -> exactly 11 bytes "00:00:00.00".
REQ-028 SHALL cover: centisec=7'd127, hour=5'd31 -> hour "31", centisec "99".
REQ-029 SHALL cover: second i_send pulse and time_data change during a frame -> no extra frame, frame content equals the first snapshot.
REQ-030 SHALL cover: rst asserted after byte 5 -> tx_start=0, o_busy=0 next cycle; subsequent i_send -> full frame from byte "H".
REQ-031 SHALL cover, with AUTO_REPORT_EN: sec field stepping 6'd9 -> 6'd10 -> one frame with "10" in the sec position, and no frame while sec is constant.
